// File: rtl/traffic_interval_timer.sv
// Interval timer for the traffic-light controller: prescales the system clock into ticks,
// counts ticks since the last t_reset and flags when the long and yellow intervals have elapsed.
module traffic_interval_timer #(
  parameter int CLK_PER_TICK = 1000,
  parameter int TICK_W       = 8,
  parameter int DEF_LONG     = 15,
  parameter int DEF_YELLOW   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              t_reset,
  input  logic              cfg_we,
  input  logic              cfg_sel,
  input  logic [TICK_W-1:0] cfg_data,
  output logic              time_country,
  output logic              time_yellow,
  output logic              tick,
  output logic [TICK_W-1:0] elapsed
);

  localparam int PW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(CLK_PER_TICK - 1);
  localparam logic [TICK_W-1:0] ELAPSED_MAX = {TICK_W{1'b1}};
  localparam logic [TICK_W-1:0] LONG_RST    = TICK_W'(DEF_LONG);
  localparam logic [TICK_W-1:0] YEL_RST     = TICK_W'(DEF_YELLOW);

  logic [PW-1:0]     presc_q, presc_d;
  logic [TICK_W-1:0] elapsed_q, elapsed_d;
  logic [TICK_W-1:0] long_sh_q, long_sh_d, yel_sh_q, yel_sh_d;
  logic [TICK_W-1:0] long_act_q, long_act_d, yel_act_q, yel_act_d;
  logic              tc_q, tc_d, ty_q, ty_d;

  assign tick         = (presc_q == PRESC_LAST) && !t_reset;
  assign elapsed      = elapsed_q;
  assign time_country = tc_q;
  assign time_yellow  = ty_q;

  always_comb begin
    presc_d    = presc_q;
    elapsed_d  = elapsed_q;
    long_sh_d  = long_sh_q;
    yel_sh_d   = yel_sh_q;
    long_act_d = long_act_q;
    yel_act_d  = yel_act_q;
    tc_d       = tc_q;
    ty_d       = ty_q;

    if (cfg_we && !cfg_sel) long_sh_d = cfg_data;
    if (cfg_we &&  cfg_sel) yel_sh_d  = cfg_data;

    if (t_reset) begin
      // Loading from the post-write shadow values lets a same-edge cfg write govern the next interval.
      presc_d    = '0;
      elapsed_d  = '0;
      tc_d       = 1'b0;
      ty_d       = 1'b0;
      long_act_d = long_sh_d;
      yel_act_d  = yel_sh_d;
    end else begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
      if (tick && (elapsed_q != ELAPSED_MAX)) elapsed_d = elapsed_q + 1'b1;
      tc_d = tc_q | (elapsed_d >= long_act_q);
      ty_d = ty_q | (elapsed_d >= yel_act_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q    <= '0;
      elapsed_q  <= '0;
      long_sh_q  <= LONG_RST;
      yel_sh_q   <= YEL_RST;
      long_act_q <= LONG_RST;
      yel_act_q  <= YEL_RST;
      tc_q       <= 1'b0;
      ty_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      elapsed_q  <= elapsed_d;
      long_sh_q  <= long_sh_d;
      yel_sh_q   <= yel_sh_d;
      long_act_q <= long_act_d;
      yel_act_q  <= yel_act_d;
      tc_q       <= tc_d;
      ty_q       <= ty_d;
    end
  end

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Directed bench for traffic_interval_timer with CLK_PER_TICK=4, DEF_LONG=5, DEF_YELLOW=2.
module tb_traffic_interval_timer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       t_reset = 1'b0;
  logic       cfg_we = 1'b0;
  logic       cfg_sel = 1'b0;
  logic [7:0] cfg_data = '0;
  logic       time_country, time_yellow, tick;
  logic [7:0] elapsed;

  int checks = 0;
  int errors = 0;

  traffic_interval_timer #(
    .CLK_PER_TICK(4), .TICK_W(8), .DEF_LONG(5), .DEF_YELLOW(2)
  ) dut (
    .clock(clock), .reset(reset), .t_reset(t_reset), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .time_country(time_country),
    .time_yellow(time_yellow), .tick(tick), .elapsed(elapsed)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1; t_reset = 1'b0; cfg_we = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp_v;
    apply_reset();
    exp_v = '0;
    checks++;
    if ({tick, time_yellow, time_country, elapsed} !== exp_v) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {tick, time_yellow, time_country, elapsed}, exp_v);
    end
  endtask

  task automatic test_free_run(input string name);
    logic [9:0] exp_v;
    int el;
    for (int e = 1; e <= 24; e++) begin
      checks++;
      if (tick !== ((e % 4) == 0)) begin
        errors++;
        $display("FAIL %s_tick edge %0d: got %b expected %b", name, e, tick, ((e % 4) == 0));
      end
      step();
      el = e / 4;
      exp_v = {el >= 2, el >= 5, 8'(el)};
      checks++;
      if ({time_yellow, time_country, elapsed} !== exp_v) begin
        errors++;
        $display("FAIL %s edge %0d: got %h expected %h", name, e, {time_yellow, time_country, elapsed}, exp_v);
      end
    end
  endtask

  task automatic test_t_reset_hold();
    logic [9:0] exp_v;
    int el;
    apply_reset();
    for (int e = 1; e <= 9; e++) step();
    t_reset = 1'b1;
    #1;
    for (int e = 10; e <= 13; e++) begin
      checks++;
      if (tick !== 1'b0) begin
        errors++;
        $display("FAIL hold_tick edge %0d: got %b expected 0", e, tick);
      end
      step();
      checks++;
      if ({time_yellow, time_country, elapsed} !== 10'h0) begin
        errors++;
        $display("FAIL hold_state edge %0d: got %h expected 000", e, {time_yellow, time_country, elapsed});
      end
    end
    t_reset = 1'b0;
    #1;
    for (int k = 1; k <= 8; k++) begin
      checks++;
      if (tick !== ((k % 4) == 0)) begin
        errors++;
        $display("FAIL release_tick k %0d: got %b expected %b", k, tick, ((k % 4) == 0));
      end
      step();
      el = k / 4;
      exp_v = {k >= 8, 1'b0, 8'(el)};
      checks++;
      if ({time_yellow, time_country, elapsed} !== exp_v) begin
        errors++;
        $display("FAIL release k %0d: got %h expected %h", k, {time_yellow, time_country, elapsed}, exp_v);
      end
    end
    // t_reset asserted while the prescaler sits on its last count must mask tick.
    apply_reset();
    for (int e = 1; e <= 3; e++) step();
    checks++;
    if (tick !== 1'b1) begin
      errors++;
      $display("FAIL presupp_tick: got %b expected 1", tick);
    end
    t_reset = 1'b1;
    #1;
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL suppressed_tick: got %b expected 0", tick);
    end
    step();
    t_reset = 1'b0;
    checks++;
    if (elapsed !== 8'd0) begin
      errors++;
      $display("FAIL suppressed_elapsed: got %0d expected 0", elapsed);
    end
  endtask

  task automatic test_cfg_shadow();
    logic [9:0] exp_v;
    apply_reset();
    for (int e = 1; e <= 5; e++) step();
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd3;
    step();
    cfg_we = 1'b0;
    for (int e = 7; e <= 19; e++) step();
    checks++;
    if ({time_country, elapsed} !== {1'b0, 8'd4}) begin
      errors++;
      $display("FAIL shadow_e19: got %h expected %h", {time_country, elapsed}, {1'b0, 8'd4});
    end
    step();
    checks++;
    if ({time_country, elapsed} !== {1'b1, 8'd5}) begin
      errors++;
      $display("FAIL shadow_e20: got %h expected %h", {time_country, elapsed}, {1'b1, 8'd5});
    end
    t_reset = 1'b1;
    step();
    t_reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_v = {k >= 8, k >= 12, 8'(k / 4)};
      checks++;
      if ({time_yellow, time_country, elapsed} !== exp_v) begin
        errors++;
        $display("FAIL new_long k %0d: got %h expected %h", k, {time_yellow, time_country, elapsed}, exp_v);
      end
    end
  endtask

  task automatic test_cfg_through();
    logic [9:0] exp_v;
    apply_reset();
    step();
    step();
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_data = 8'd0; t_reset = 1'b1;
    step();
    cfg_we = 1'b0; t_reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_v = {1'b1, k >= 20, 8'(k / 4)};
      checks++;
      if ({time_yellow, time_country, elapsed} !== exp_v) begin
        errors++;
        $display("FAIL through k %0d: got %h expected %h", k, {time_yellow, time_country, elapsed}, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    logic [9:0] exp_v;
    int el;
    apply_reset();
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd255; t_reset = 1'b1;
    step();
    cfg_we = 1'b0; t_reset = 1'b0;
    for (int k = 1; k <= 1200; k++) begin
      step();
      el = (k / 4 > 255) ? 255 : k / 4;
      exp_v = {el >= 2, el >= 255, 8'(el)};
      checks++;
      if ({time_yellow, time_country, elapsed} !== exp_v) begin
        errors++;
        $display("FAIL saturate k %0d: got %h expected %h", k, {time_yellow, time_country, elapsed}, exp_v);
      end
    end
  endtask

  task automatic test_reset_restores();
    apply_reset();
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd3; t_reset = 1'b1;
    step();
    cfg_sel = 1'b1; cfg_data = 8'd1;
    step();
    cfg_we = 1'b0; t_reset = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if ({time_yellow, elapsed} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL custom_yellow: got %h expected %h", {time_yellow, elapsed}, {1'b1, 8'd1});
    end
    step();
    reset = 1'b1; cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 8'd1;
    step();
    cfg_sel = 1'b1; cfg_data = 8'd0;
    step();
    reset = 1'b0; cfg_we = 1'b0;
    #1;
    checks++;
    if ({tick, time_yellow, time_country, elapsed} !== 11'h0) begin
      errors++;
      $display("FAIL restore_state: got %h expected 000", {tick, time_yellow, time_country, elapsed});
    end
    test_free_run("restored");
  endtask

  initial begin
    test_reset();
    test_free_run("free_run");
    test_t_reset_hold();
    test_cfg_shadow();
    test_cfg_through();
    test_saturation();
    test_reset_restores();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/traffic_interval_timer.md
Name: traffic_interval_timer

Overview:
Interval timer and configuration holder for the traffic-light next-state controller. It converts the fast system clock into a slow tick. It counts ticks since the controller's last t_reset pulse and drives the time_country (long interval) and time_yellow (yellow interval) inputs of the controller. Both interval lengths are software-configurable through a simple write port; new values take effect at the next interval restart.

Parameters:
CLK_PER_TICK, 1000, system clocks per timer tick (prescaler modulus, must be >= 2)
TICK_W, 8, width of elapsed counter and interval registers
DEF_LONG, 15, reset value of long (country/green) interval, in ticks
DEF_YELLOW, 3, reset value of yellow interval, in ticks

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
t_reset  input  1  interval restart request from controller (level, may be held multiple cycles)
cfg_we  input  1  configuration write strobe (one write per cycle)
cfg_sel  input  1  0 = long interval, 1 = yellow interval
cfg_data  input  TICK_W  interval value in ticks
time_country  output  1  high once elapsed >= active long interval
time_yellow  output  1  high once elapsed >= active yellow interval
tick  output  1  one-cycle pulse at each prescaler wrap
elapsed  output  TICK_W  ticks since last restart (saturating)

Behaviour:
- Decided interface: one clock; reset is synchronous and active-high (ports named clock and reset).
- Priority on every edge: reset > t_reset > normal counting; cfg writes are processed in parallel with t_reset and counting.
- Reset: prescaler=0, elapsed=0, tick=0, time_country=0, time_yellow=0. Shadow and active long intervals = DEF_LONG; shadow and active yellow intervals = DEF_YELLOW. A cfg_we in the reset cycle is ignored.
- Prescaler: counts 0..CLK_PER_TICK-1 and wraps to 0. The tick output is combinational: (prescaler == CLK_PER_TICK-1) and not t_reset.
- elapsed: increments on an edge where tick=1 and saturates at 2^TICK_W-1 (no wrap).
- time_country / time_yellow are registered. On each non-reset, non-t_reset edge they take (elapsed_next >= active_interval), where elapsed_next is the value being loaded into elapsed. They therefore rise on the same edge that elapsed reaches the interval value.
  - Once high they stay high until t_reset or reset, even under saturation.
  - An interval value of 0 makes the output rise on the first edge after t_reset falls.
- t_reset high (any number of cycles): prescaler=0, elapsed=0, both outputs forced 0, tick suppressed. Active intervals are loaded from the shadow registers on every t_reset cycle. Counting restarts on the first edge with t_reset low.
- cfg write: when cfg_we=1, cfg_data is written into the shadow register selected by cfg_sel.
  - Active registers are not affected until the next t_reset.
  - If cfg_we and t_reset are high on the same edge, the new data is written through to the active register as well, so it governs the interval that follows.
- The two outputs are independent comparisons; both may be high simultaneously. The controller ignores whichever one does not apply to its current state.
- Reset in mid-interval discards shadow changes and restores the defaults.

Test Plan:
CLK_PER_TICK=4, TICK_W=8, DEF_LONG=5, DEF_YELLOW=2 for all scenarios; cycles are counted as edges after reset falls.
1. Reset, then free run -> tick high on edges 4, 8, 12...; elapsed=2 and time_yellow=1 from edge 8; elapsed=5 and time_country=1 from edge 20; both stay high.
2. At edge 10, hold t_reset 4 cycles -> elapsed=0, outputs 0, tick=0 throughout. The first tick comes 4 edges after t_reset falls, and time_yellow rises 8 edges after it falls.
3. Write cfg_sel=0, cfg_data=3 at edge 6 with no t_reset -> time_country still rises at edge 20. After a t_reset pulse, time_country rises 12 edges after t_reset falls.
4. Write cfg_sel=1, cfg_data=0 on the same edge as t_reset -> time_yellow high on the first edge after t_reset falls; time_country unchanged (default 5 ticks).
5. Set long=255 via cfg plus t_reset, then run 300 ticks -> elapsed saturates at 255 and stays; time_country rises at 255 and holds.
6. Write long=3 and yellow=1, then assert reset mid-interval -> after reset, timing matches scenario 1 (defaults restored; cfg_we during reset ignored).
